// File: rtl/sap_cpu_core_if.sv
// ---------------------------------------------------------------------------
// sap_cpu_core_if
//   Bus bundle for sap_cpu_core: run control, RAM programming port and the
//   architectural status/output signals that the board top consumes.
//
//   master : drives run / prog_*, observes outputs (board top, testbench)
//   slave  : the core itself
//
//   Signals:
//     run        1 = sequencer advances, 0 = frozen in current T-state
//     prog_we    RAM write strobe (honoured only when stopped or halted)
//     prog_addr  programming address
//     prog_data  programming data
//     out_data   output register O
//     out_valid  one-cycle pulse after O is written
//     halted     high once HLT has executed
//     carry_flag CF
//     zero_flag  ZF
//     pc         program counter
// ---------------------------------------------------------------------------
interface sap_cpu_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              run;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;
    logic              carry_flag;
    logic              zero_flag;
    logic [ADDR_W-1:0] pc;

    modport master (
        output run, prog_we, prog_addr, prog_data,
        input  out_data, out_valid, halted, carry_flag, zero_flag, pc
    );

    modport slave (
        input  run, prog_we, prog_addr, prog_data,
        output out_data, out_valid, halted, carry_flag, zero_flag, pc
    );
endinterface

// File: rtl/sap_cpu_core.sv
// ---------------------------------------------------------------------------
// sap_cpu_core
//   Parametrised accumulator CPU with an explicit T0..T4 sequencer, internal
//   program/data RAM (combinational read, synchronous write), carry and zero
//   flags, conditional jumps and an output register with a valid strobe.
//
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous, active-high reset (RAM contents are kept)
//     bus  sap_cpu_core_if.slave: run, prog_we/addr/data, out_data,
//          out_valid, halted, carry_flag, zero_flag, pc
//
//   Parameters:
//     DATA_W  datapath / RAM word width, must be >= 4 + ADDR_W
//     ADDR_W  address width, RAM depth = 2**ADDR_W
//
//   Build option:
//     SAP_VARCYCLE_EN  when defined, the sequencer returns to T0 right after
//                      the last useful T-state (3/4/5-cycle instructions).
//                      Undefined: every instruction takes 5 cycles.
// ---------------------------------------------------------------------------
module sap_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    sap_cpu_core_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if (DATA_W < 4 + ADDR_W) begin : g_bad_width
            $error("sap_cpu_core: DATA_W must be >= 4 + ADDR_W");
        end
    endgenerate

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} tstate_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } op_e;

    tstate_e           state_q, state_d;
    logic [DATA_W-1:0] a_q, b_q, ir_q, o_q;
    logic [ADDR_W-1:0] mar_q, pc_q;
    logic              cf_q, zf_q, halted_q, out_valid_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              advance;
    op_e               opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] ram_rd;
    logic              is_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   alu_res;
    logic              core_we;
    logic              prog_ok;

    assign advance = bus.run && !halted_q;
    assign opcode  = op_e'(ir_q[DATA_W-1 -: 4]);
    assign operand = ir_q[ADDR_W-1:0];
    assign ram_rd  = mem[mar_q];

    // Subtraction is A + ~B + 1, so CF=1 means "no borrow".
    assign is_sub  = (opcode == OP_SUB);
    assign b_eff   = is_sub ? ~b_q : b_q;
    assign alu_res = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= T0;
        else     state_q <= state_d;
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (advance) begin
            case (state_q)
                T0: state_d = T1;
                T1: state_d = T2;
`ifdef SAP_VARCYCLE_EN
                T2: state_d = (opcode == OP_LDA || opcode == OP_STA ||
                               opcode == OP_ADD || opcode == OP_SUB) ? T3 : T0;
                T3: state_d = (opcode == OP_ADD || opcode == OP_SUB) ? T4 : T0;
`else
                T2: state_d = T3;
                T3: state_d = T4;
`endif
                T4: state_d = T0;
                default: state_d = T0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Architectural registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            ir_q        <= '0;
            mar_q       <= '0;
            pc_q        <= '0;
            o_q         <= '0;
            cf_q        <= 1'b0;
            zf_q        <= 1'b0;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // Strobe lasts exactly one cycle, even if run drops right after.
            out_valid_q <= 1'b0;
            if (advance) begin
                case (state_q)
                    T0: mar_q <= pc_q;
                    T1: begin
                        ir_q <= ram_rd;
                        pc_q <= pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                    T2: begin
                        case (opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_q <= operand;
                            OP_LDI: a_q  <= {{(DATA_W-ADDR_W){1'b0}}, operand};
                            OP_JMP: pc_q <= operand;
                            OP_JC:  if (cf_q) pc_q <= operand;
                            OP_JZ:  if (zf_q) pc_q <= operand;
                            OP_OUT: begin
                                o_q         <= a_q;
                                out_valid_q <= 1'b1;
                            end
                            OP_HLT: halted_q <= 1'b1;
                            default: ;
                        endcase
                    end
                    T3: begin
                        case (opcode)
                            OP_LDA:         a_q <= ram_rd;
                            OP_ADD, OP_SUB: b_q <= ram_rd;
                            default: ;
                        endcase
                    end
                    T4: begin
                        if (opcode == OP_ADD || opcode == OP_SUB) begin
                            {cf_q, a_q} <= alu_res;
                            zf_q        <= (alu_res[DATA_W-1:0] == '0);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // RAM: the core's STA write has priority over the programming port; the
    // port itself is only honoured while the core is stopped or halted.
    // -----------------------------------------------------------------------
    assign core_we = advance && (state_q == T3) && (opcode == OP_STA);
    assign prog_ok = bus.prog_we && (!bus.run || halted_q);

    // NOTE: the RAM has no reset on purpose; a program loaded before reset
    // must survive it, and array resets would also block RAM inference.
    always_ff @(posedge clk) begin
        if (core_we)      mem[mar_q]         <= a_q;
        else if (prog_ok) mem[bus.prog_addr] <= bus.prog_data;
    end

    assign bus.out_data   = o_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.halted     = halted_q;
    assign bus.carry_flag = cf_q;
    assign bus.zero_flag  = zf_q;
    assign bus.pc         = pc_q;

endmodule

// File: tb/tb_sap_cpu_core.sv
// ---------------------------------------------------------------------------
// tb_sap_cpu_core
//   Directed self-checking bench for sap_cpu_core (DATA_W=8, ADDR_W=4).
//   Programs are loaded through the programming port, run to HLT, and the
//   output value, strobe count, flags, PC and halt timing are compared with
//   hand-computed values. Halt timing follows SAP_VARCYCLE_EN.
// ---------------------------------------------------------------------------
module tb_sap_cpu_core;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

`ifdef SAP_VARCYCLE_EN
    localparam int HALT_T1 = 15;
    localparam int HALT_T2 = 14;
    localparam int HALT_T3 = 21;
    localparam int HALT_T4 = 12;
    localparam int HALT_T6 = 23;
    localparam int WRAP_T6 = 16;
`else
    localparam int HALT_T1 = 18;
    localparam int HALT_T2 = 18;
    localparam int HALT_T3 = 28;
    localparam int HALT_T4 = 15;
    localparam int HALT_T6 = 33;
    localparam int WRAP_T6 = 22;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    int pc_trace [0:255];

    sap_cpu_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sap_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic prog(input int addr, input int data);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr[ADDR_W-1:0];
        bus.prog_data = data[DATA_W-1:0];
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.run = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
    endtask

    // Raises run, counts edges until halted (bounded), then drops run.
    task automatic run_prog(input int max_edges, output int halt_edge,
                            output int pulses, output logic [7:0] last_out);
        halt_edge = 0;
        pulses    = 0;
        last_out  = '0;
        @(negedge clk);
        bus.run = 1'b1;
        for (int e = 1; e <= max_edges; e++) begin
            @(posedge clk);
            #1;
            pc_trace[e] = int'(bus.pc);
            if (bus.out_valid) begin
                pulses++;
                last_out = bus.out_data;
            end
            if (bus.halted) begin
                halt_edge = e;
                break;
            end
        end
        @(negedge clk);
        bus.run = 1'b0;
    endtask

    initial begin
        int          he;
        int          np;
        logic [7:0]  ov;

        bus.run       = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;

        // Reset state
        #1;
        check("rst_pc",        bus.pc,         0);
        check("rst_out",       bus.out_data,   0);
        check("rst_valid",     bus.out_valid,  0);
        check("rst_halted",    bus.halted,     0);
        check("rst_cf",        bus.carry_flag, 0);
        check("rst_zf",        bus.zero_flag,  0);
        do_reset();

        // Test 1: LDA 14; ADD 15; OUT; HLT  -> 28 + 14 = 42
        prog(0, 8'h1E); prog(1, 8'h2F); prog(2, 8'hE0); prog(3, 8'hF0);
        prog(14, 28);   prog(15, 14);
        run_prog(200, he, np, ov);
        check("t1_out",        ov,             42);
        check("t1_pulses",     np,             1);
        check("t1_halted",     bus.halted,     1);
        check("t1_halt_edge",  he,             HALT_T1);
        check("t1_pc",         bus.pc,         4);
        check("t1_cf",         bus.carry_flag, 0);
        check("t1_zf",         bus.zero_flag,  0);
        check("t1_valid_low",  bus.out_valid,  0);

        // Test 2: LDI 3; SUB 15 (=5); OUT; HLT -> 0xFE, borrow
        prog(0, 8'h53); prog(1, 8'h3F); prog(2, 8'hE0); prog(3, 8'hF0);
        prog(15, 5);
        do_reset();
        run_prog(200, he, np, ov);
        check("t2_out",        ov,             8'hFE);
        check("t2_cf",         bus.carry_flag, 0);
        check("t2_zf",         bus.zero_flag,  0);
        check("t2_halt_edge",  he,             HALT_T2);
        // Same program with RAM[15]=3 -> 0, no borrow
        prog(15, 3);
        do_reset();
        check("t2_rst_halted", bus.halted,     0);
        check("t2_rst_pc",     bus.pc,         0);
        run_prog(200, he, np, ov);
        check("t2b_out",       ov,             0);
        check("t2b_pulses",    np,             1);
        check("t2b_cf",        bus.carry_flag, 1);
        check("t2b_zf",        bus.zero_flag,  1);

        // Test 3: LDA 14 (FF); ADD 15 (01); JC 6; OUT; HLT; 6: LDI 9; OUT; HLT
        prog(0, 8'h1E); prog(1, 8'h2F); prog(2, 8'h76); prog(3, 8'hE0);
        prog(4, 8'hF0); prog(5, 8'h00); prog(6, 8'h59); prog(7, 8'hE0);
        prog(8, 8'hF0); prog(14, 8'hFF); prog(15, 8'h01);
        do_reset();
        run_prog(200, he, np, ov);
        check("t3_out",        ov,             9);
        check("t3_pulses",     np,             1);
        check("t3_cf",         bus.carry_flag, 1);
        check("t3_zf",         bus.zero_flag,  1);
        check("t3_pc",         bus.pc,         9);
        check("t3_halt_edge",  he,             HALT_T3);

        // Test 4: freeze for 7 cycles with LDA sitting in T3
        prog(0, 8'h1E); prog(1, 8'h2F); prog(2, 8'hE0); prog(3, 8'hF0);
        prog(14, 28);   prog(15, 14);
        do_reset();
        @(negedge clk);
        bus.run = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("t4_pc_%0d", i),    bus.pc,              1);
            check($sformatf("t4_state_%0d", i), int'(dut.state_q),   3);
            check($sformatf("t4_a_%0d", i),     dut.a_q,             0);
        end
        run_prog(200, he, np, ov);
        check("t4_out",        ov,             42);
        check("t4_pulses",     np,             1);
        check("t4_halt_edge",  he,             HALT_T4);

        // Test 5a: prog_we while running is ignored
        do_reset();
        @(negedge clk);
        bus.run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd14;
        bus.prog_data = 8'h55;
        @(negedge clk);
        bus.prog_we   = 1'b0;
        run_prog(200, he, np, ov);
        check("t5_ignored_out", ov,            42);

        // Test 5b: reset in the middle of the program
        do_reset();
        @(negedge clk);
        bus.run = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        bus.run = 1'b0;
        rst     = 1'b1;
        #1;
        check("t5_mid_pc",     bus.pc,         0);
        check("t5_mid_halted", bus.halted,     0);
        check("t5_mid_out",    bus.out_data,   0);
        check("t5_mid_a",      dut.a_q,        0);
        @(negedge clk);
        rst = 1'b0;
        run_prog(200, he, np, ov);
        check("t5_retained",   ov,             42);

        // Test 5c: prog_we with run=0 lands -> 0x55 + 14 = 0x63
        prog(14, 8'h55);
        do_reset();
        run_prog(200, he, np, ov);
        check("t5_written",    ov,             8'h63);

        // Test 6: PC wrap; STA patches address 1 to HLT before the wrap
        for (int i = 0; i < 16; i++) prog(i, 0);
        prog(0, 8'hE0); prog(1, 8'h1D); prog(2, 8'h41); prog(3, 8'h6F);
        prog(13, 8'hF0);
        do_reset();
        run_prog(200, he, np, ov);
        check("t6_pc_at15",    pc_trace[WRAP_T6-1], 15);
        check("t6_pc_wrap",    pc_trace[WRAP_T6],   0);
        check("t6_pulses",     np,             2);
        check("t6_out",        ov,             8'hF0);
        check("t6_halt_edge",  he,             HALT_T6);
        check("t6_pc_final",   bus.pc,         2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
